// File: rtl/uart_tx_frame.sv
// UART transmit serialiser: 5..MAX_DATA_W data bits, optional parity (even/odd/mark/space),
// one or two stop bits, break generation and an optional one-entry holding register.
module uart_tx_frame #(
    parameter int MAX_DATA_W = 8,
    parameter int HOLD_EN    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  xmit_pulse,
    input  logic [MAX_DATA_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [3:0]            data_bits,
    input  logic                  parity_en,
    input  logic [1:0]            parity_mode,
    input  logic                  stop2,
    input  logic                  break_req,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  break_active
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;
    localparam logic [2:0] ST_BREAK  = 3'd6;

    localparam logic [1:0] PAR_EVEN  = 2'd0;
    localparam logic [1:0] PAR_ODD   = 2'd1;
    localparam logic [1:0] PAR_MARK  = 2'd2;
    localparam logic [1:0] PAR_SPACE = 2'd3;

    localparam logic [3:0] MIN_LEN = 4'd5;
    localparam logic [3:0] MAX_LEN = 4'(MAX_DATA_W);

    function automatic logic [3:0] clamp_len(input logic [3:0] req);
        logic [3:0] len;
        if ((req >= MIN_LEN) && (req <= MAX_LEN)) begin
            len = req;
        end else begin
            len = MAX_LEN;
        end
        return len;
    endfunction

    function automatic logic parity_bit(input logic acc, input logic [1:0] mode);
        logic bit_v;
        case (mode)
            PAR_EVEN:  bit_v = acc;
            PAR_ODD:   bit_v = ~acc;
            PAR_MARK:  bit_v = 1'b1;
            PAR_SPACE: bit_v = 1'b0;
            default:   bit_v = acc;
        endcase
        return bit_v;
    endfunction

    logic [MAX_DATA_W-1:0] hold_data_r;
    logic [3:0]            hold_len_r;
    logic                  hold_par_en_r;
    logic [1:0]            hold_par_mode_r;
    logic                  hold_stop2_r;
    logic                  hold_full_r;
    logic                  hold_full_s;

    logic [MAX_DATA_W-1:0] sh_data_r,     sh_data_s;
    logic [3:0]            sh_len_r,      sh_len_s;
    logic                  sh_par_en_r,   sh_par_en_s;
    logic [1:0]            sh_par_mode_r, sh_par_mode_s;
    logic                  sh_stop2_r,    sh_stop2_s;
    logic [3:0]            bit_cnt_r,     bit_cnt_s;
    logic                  par_acc_r,     par_acc_s;
    logic                  brk_mark_r,    brk_mark_s;
    logic [2:0]            state_r,       state_s;
    logic                  tx_r,          tx_s;
    logic                  tx_done_r,     tx_done_s;
    logic                  break_active_r, break_active_s;
    logic                  tx_busy_r;
    logic                  tx_ready_r,    tx_ready_s;

    logic                  accept_s;
    logic                  load_s;
    logic                  frame_end_s;

    assign accept_s = tx_valid & tx_ready_r;

    // Holding-register occupancy: set on a transfer, cleared when the shifter takes the frame.
    always_comb begin
        hold_full_s = hold_full_r;
        if (accept_s) begin
            hold_full_s = 1'b1;
        end else if (load_s) begin
            hold_full_s = 1'b0;
        end else begin
            hold_full_s = hold_full_r;
        end
    end

    // Frame sequencer: every line change and state move happens on a bit-rate tick.
    always_comb begin
        state_s        = state_r;
        tx_s           = tx_r;
        sh_data_s      = sh_data_r;
        sh_len_s       = sh_len_r;
        sh_par_en_s    = sh_par_en_r;
        sh_par_mode_s  = sh_par_mode_r;
        sh_stop2_s     = sh_stop2_r;
        bit_cnt_s      = bit_cnt_r;
        par_acc_s      = par_acc_r;
        brk_mark_s     = brk_mark_r;
        break_active_s = break_active_r;
        tx_done_s      = 1'b0;
        load_s         = 1'b0;
        frame_end_s    = 1'b0;

        if (xmit_pulse) begin
            case (state_r)
                ST_IDLE: begin
                    if (break_req) begin
                        tx_s           = 1'b0;
                        state_s        = ST_BREAK;
                        break_active_s = 1'b1;
                    end else if (hold_full_r) begin
                        load_s = 1'b1;
                    end else begin
                        tx_s = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_r < sh_len_r) begin
                        tx_s      = sh_data_r[0];
                        par_acc_s = par_acc_r ^ sh_data_r[0];
                        sh_data_s = sh_data_r >> 1;
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end else if (sh_par_en_r) begin
                        tx_s    = parity_bit(par_acc_r, sh_par_mode_r);
                        state_s = ST_PARITY;
                    end else begin
                        tx_s    = 1'b1;
                        state_s = ST_STOP1;
                    end
                end
                ST_PARITY: begin
                    tx_s    = 1'b1;
                    state_s = ST_STOP1;
                end
                ST_STOP1: begin
                    if (sh_stop2_r) begin
                        tx_s    = 1'b1;
                        state_s = ST_STOP2;
                    end else begin
                        frame_end_s = 1'b1;
                    end
                end
                ST_STOP2: begin
                    frame_end_s = 1'b1;
                end
                ST_BREAK: begin
                    // Release always passes through one mark bit (a single stop period).
                    if (!break_req) begin
                        tx_s           = 1'b1;
                        break_active_s = 1'b0;
                        brk_mark_s     = 1'b1;
                        sh_stop2_s     = 1'b0;
                        state_s        = ST_STOP1;
                    end else begin
                        tx_s = 1'b0;
                    end
                end
                default: begin
                    tx_s           = 1'b1;
                    break_active_s = 1'b0;
                    state_s        = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        if (frame_end_s) begin
            tx_done_s  = ~brk_mark_r;
            brk_mark_s = 1'b0;
            if (hold_full_r && !break_req) begin
                load_s = 1'b1;
            end else begin
                tx_s    = 1'b1;
                state_s = ST_IDLE;
            end
        end else begin
            brk_mark_s = brk_mark_s;
        end

        if (load_s) begin
            tx_s          = 1'b0;
            state_s       = ST_DATA;
            sh_data_s     = hold_data_r;
            sh_len_s      = hold_len_r;
            sh_par_en_s   = hold_par_en_r;
            sh_par_mode_s = hold_par_mode_r;
            sh_stop2_s    = hold_stop2_r;
            bit_cnt_s     = 4'd0;
            par_acc_s     = 1'b0;
        end else begin
            bit_cnt_s = bit_cnt_s;
        end
    end

    // Acceptance: with a holding register only its occupancy matters, otherwise the shifter must be idle.
    always_comb begin
        tx_ready_s = 1'b0;
        if (HOLD_EN != 0) begin
            tx_ready_s = ~hold_full_s;
        end else begin
            tx_ready_s = (state_s == ST_IDLE) & ~break_active_s & ~hold_full_s;
        end
    end

    // Holding register: captures data and frame configuration together on a transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full_r     <= 1'b0;
            hold_data_r     <= '0;
            hold_len_r      <= MAX_LEN;
            hold_par_en_r   <= 1'b0;
            hold_par_mode_r <= PAR_EVEN;
            hold_stop2_r    <= 1'b0;
        end else begin
            hold_full_r <= hold_full_s;
            if (accept_s) begin
                hold_data_r     <= tx_data;
                hold_len_r      <= clamp_len(data_bits);
                hold_par_en_r   <= parity_en;
                hold_par_mode_r <= parity_mode;
                hold_stop2_r    <= stop2;
            end
        end
    end

    // Sequencer and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            tx_r           <= 1'b1;
            tx_done_r      <= 1'b0;
            break_active_r <= 1'b0;
            tx_busy_r      <= 1'b0;
            tx_ready_r     <= 1'b1;
            sh_data_r      <= '0;
            sh_len_r       <= MAX_LEN;
            sh_par_en_r    <= 1'b0;
            sh_par_mode_r  <= PAR_EVEN;
            sh_stop2_r     <= 1'b0;
            bit_cnt_r      <= 4'd0;
            par_acc_r      <= 1'b0;
            brk_mark_r     <= 1'b0;
        end else begin
            state_r        <= state_s;
            tx_r           <= tx_s;
            tx_done_r      <= tx_done_s;
            break_active_r <= break_active_s;
            tx_busy_r      <= (state_s != ST_IDLE);
            tx_ready_r     <= tx_ready_s;
            sh_data_r      <= sh_data_s;
            sh_len_r       <= sh_len_s;
            sh_par_en_r    <= sh_par_en_s;
            sh_par_mode_r  <= sh_par_mode_s;
            sh_stop2_r     <= sh_stop2_s;
            bit_cnt_r      <= bit_cnt_s;
            par_acc_r      <= par_acc_s;
            brk_mark_r     <= brk_mark_s;
        end
    end

    assign tx           = tx_r;
    assign tx_done      = tx_done_r;
    assign tx_busy      = tx_busy_r;
    assign tx_ready     = tx_ready_r;
    assign break_active = break_active_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed frames plus randomized traffic
// compared every clock against a queue-based line model.
module tb_uart_tx_frame;

    localparam int MAXW = 8;
    typedef bit bitq_t[$];

    logic            clk = 1'b0;
    logic            reset, xmit_pulse, tx_valid, parity_en, stop2, break_req;
    logic [MAXW-1:0] tx_data;
    logic [3:0]      data_bits;
    logic [1:0]      parity_mode;
    logic            tx, tx_ready, tx_busy, tx_done, break_active;

    always #5 clk = ~clk;

    uart_tx_frame #(.MAX_DATA_W(MAXW), .HOLD_EN(1)) dut (
        .clk(clk), .reset(reset), .xmit_pulse(xmit_pulse), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .data_bits(data_bits),
        .parity_en(parity_en), .parity_mode(parity_mode), .stop2(stop2),
        .break_req(break_req), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done),
        .break_active(break_active)
    );

    int checks = 0;
    int failures = 0;
    int pulse_mode = 0;
    int pcnt = 0;

    bitq_t m_cur, m_pend;
    bit    m_pending = 0, m_frame_on = 0, m_brk = 0, m_brk_rec = 0;
    logic  e_tx = 1'b1, e_done = 1'b0, e_busy = 1'b0, e_brk = 1'b0, e_ready = 1'b1;
    bit    log_tx[$];
    bit    log_done[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired at %0t", tag, $time);
    endtask

    // Line bits of one frame, start bit first, from data and captured configuration.
    function automatic bitq_t build_frame(input logic [MAXW-1:0] d, input logic [3:0] db,
                                          input logic pe, input logic [1:0] pm, input logic s2);
        bitq_t q;
        int    n;
        bit    ones;
        n = (db >= 4'd5 && int'(db) <= MAXW) ? int'(db) : MAXW;
        ones = 1'b0;
        q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            q.push_back(d[i]);
            ones ^= d[i];
        end
        if (pe) begin
            if (pm == 2'd0)      q.push_back(ones);
            else if (pm == 2'd1) q.push_back(~ones);
            else if (pm == 2'd2) q.push_back(1'b1);
            else                 q.push_back(1'b0);
        end
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        return q;
    endfunction

    // Advance the model by one clock using the inputs presented for the coming edge.
    task automatic model_edge();
        bit xfer;
        if (reset) begin
            m_cur = {}; m_pend = {};
            m_pending = 0; m_frame_on = 0; m_brk = 0; m_brk_rec = 0;
            e_tx = 1'b1; e_done = 1'b0; e_busy = 1'b0; e_brk = 1'b0; e_ready = 1'b1;
            return;
        end
        xfer = tx_valid && e_ready;
        e_done = 1'b0;
        if (xmit_pulse) begin
            if (m_brk) begin
                if (break_req) begin
                    e_tx = 1'b0;
                end else begin
                    e_tx = 1'b1; m_brk = 0; m_frame_on = 1; m_brk_rec = 1;
                end
            end else if (m_cur.size() > 0) begin
                e_tx = m_cur.pop_front();
            end else if (m_frame_on) begin
                e_done = !m_brk_rec;
                m_brk_rec = 0;
                if (m_pending && !break_req) begin
                    m_cur = m_pend; m_pending = 0;
                    e_tx = m_cur.pop_front();
                end else begin
                    m_frame_on = 0; e_tx = 1'b1;
                end
            end else if (break_req) begin
                m_brk = 1; e_tx = 1'b0;
            end else if (m_pending) begin
                m_cur = m_pend; m_pending = 0; m_frame_on = 1;
                e_tx = m_cur.pop_front();
            end
        end
        if (xfer) begin
            m_pend = build_frame(tx_data, data_bits, parity_en, parity_mode, stop2);
            m_pending = 1;
        end
        e_busy  = m_frame_on || m_brk;
        e_brk   = m_brk;
        e_ready = !m_pending;
    endtask

    task automatic step();
        if (pulse_mode == 0) xmit_pulse = (pcnt % 3 == 0);
        else                 xmit_pulse = ($urandom_range(0, 2) == 0);
        pcnt++;
        model_edge();
        @(posedge clk);
        #1;
        check_eq("tx", tx, e_tx);
        check_eq("tx_done", tx_done, e_done);
        check_eq("tx_busy", tx_busy, e_busy);
        check_eq("break_active", break_active, e_brk);
        check_eq("tx_ready", tx_ready, e_ready);
        if (xmit_pulse) begin
            log_tx.push_back(tx);
            log_done.push_back(tx_done);
        end
    endtask

    task automatic send(input logic [MAXW-1:0] d, input bit clear_log);
        bit done_x = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        for (int g = 0; g < 500 && !done_x; g++) begin
            done_x = e_ready;
            step();
        end
        tx_valid = 1'b0;
        if (!done_x) timeout_fail("send");
        if (clear_log) begin
            log_tx = {}; log_done = {};
        end
    endtask

    task automatic wait_log(input int n);
        int g = 0;
        while (log_tx.size() < n && g < 3000) begin
            step();
            g++;
        end
        if (log_tx.size() < n) timeout_fail("wait_log");
    endtask

    function automatic logic [31:0] pack_log(input int start, input int n);
        logic [31:0] v = '0;
        for (int i = start; i < start + n; i++) begin
            v = {v[30:0], (i < log_tx.size()) ? log_tx[i] : 1'b1};
        end
        return v;
    endfunction

    function automatic int first_done(input int start);
        for (int i = start; i < log_done.size(); i++) begin
            if (log_done[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_cfg(input logic [3:0] db, input logic pe, input logic [1:0] pm, input logic s2);
        data_bits = db; parity_en = pe; parity_mode = pm; stop2 = s2;
    endtask

    initial begin
        int zeros;
        reset = 1'b1; xmit_pulse = 1'b0; tx_valid = 1'b0; tx_data = '0;
        break_req = 1'b0;
        set_cfg(4'd8, 1'b0, 2'd0, 1'b0);
        repeat (3) step();
        reset = 1'b0;
        repeat (4) step();

        // 8N1, 0xA5
        send(8'hA5, 1'b1);
        wait_log(11);
        check_eq("8n1_bits", pack_log(0, 10), 32'b0101001011);
        check_eq("8n1_done_idx", first_done(0), 32'd10);
        check_eq("8n1_busy_after", tx_busy, 32'd0);

        // 7O2, 0x41
        set_cfg(4'd7, 1'b1, 2'd1, 1'b1);
        send(8'h41, 1'b1);
        wait_log(12);
        check_eq("7o2_bits", pack_log(0, 11), 32'b01000001111);
        check_eq("7o2_done_idx", first_done(0), 32'd11);

        // Gapless back-to-back frames
        set_cfg(4'd8, 1'b0, 2'd0, 1'b0);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b0);
        wait_log(22);
        check_eq("gap_first_bits", pack_log(0, 10), 32'b0000000001);
        check_eq("gap_done", log_done[10], 32'd1);
        check_eq("gap_start_on_done", log_tx[10], 32'd0);
        check_eq("gap_second_bits", pack_log(10, 10), 32'b0111111111);

        // Break raised mid-frame with a frame queued behind it
        send(8'h55, 1'b1);
        wait_log(3);
        break_req = 1'b1;
        send(8'h3C, 1'b0);
        wait_log(16);
        check_eq("brk_frame_bits", pack_log(0, 10), 32'b0101010101);
        check_eq("brk_frame_done", log_done[10], 32'd1);
        check_eq("brk_low", pack_log(11, 5), 32'd0);
        check_eq("brk_active_flag", break_active, 32'd1);
        break_req = 1'b0;
        wait_log(17);
        check_eq("brk_mark_tx", log_tx[16], 32'd1);
        check_eq("brk_mark_nodone", log_done[16], 32'd0);
        wait_log(28);
        check_eq("brk_queued_bits", pack_log(17, 10), 32'b0001111001);
        check_eq("brk_queued_done", log_done[27], 32'd1);

        // Length clamp with mark parity
        set_cfg(4'd15, 1'b1, 2'd2, 1'b0);
        send(8'h80, 1'b1);
        wait_log(12);
        check_eq("clamp_bits", pack_log(0, 11), 32'b00000000111);
        check_eq("clamp_done_idx", first_done(0), 32'd11);

        // Reset in the middle of the data bits with a frame held
        set_cfg(4'd8, 1'b0, 2'd0, 1'b0);
        send(8'hC3, 1'b1);
        send(8'h99, 1'b0);
        wait_log(4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("rst_tx", tx, 32'd1);
        check_eq("rst_ready", tx_ready, 32'd1);
        check_eq("rst_busy", tx_busy, 32'd0);
        log_tx = {}; log_done = {};
        wait_log(15);
        zeros = 0;
        foreach (log_tx[i]) if (!log_tx[i]) zeros++;
        check_eq("rst_hold_dropped", zeros, 32'd0);

        // Randomized traffic, configuration churn, breaks and occasional resets
        pulse_mode = 1;
        log_tx = {}; log_done = {};
        for (int c = 0; c < 8000; c++) begin
            tx_valid    = ($urandom_range(0, 2) == 0);
            tx_data     = MAXW'($urandom);
            data_bits   = 4'($urandom_range(0, 15));
            parity_en   = 1'($urandom);
            parity_mode = 2'($urandom);
            stop2       = 1'($urandom);
            if ($urandom_range(0, 149) == 0) break_req = ~break_req;
            reset = ($urandom_range(0, 2999) == 0);
            step();
        end
        reset = 1'b0; tx_valid = 1'b0; break_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
